shft_seq: RTL and testbench

SHFT_SEQ -- requirements
Module: shft_seq

---
 rtl/shft_seq_pkg.sv | 28 ++
 rtl/shft_step.sv | 41 ++++
 rtl/shft_seq.sv | 124 ++++++++++++
 tb/tb_shft_seq.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/shft_seq_pkg.sv
// ---------------------------------------------------------------------------
// shft_seq_pkg
// Shared definitions for the sequential shifter:
//   - FS function-select codes (common with the ALU shifter)
//   - state encoding for the shft_seq control FSM
//   - is_shift(): true when an FS code selects one of the shift operations
// ---------------------------------------------------------------------------
package shft_seq_pkg;

    localparam int DATA_W  = 32;
    localparam int FS_W    = 5;
    localparam int COUNT_W = 5;

    localparam logic [FS_W-1:0] FS_SLL = 5'h0C;
    localparam logic [FS_W-1:0] FS_SRL = 5'h0D;
    localparam logic [FS_W-1:0] FS_SRA = 5'h0E;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    function automatic logic is_shift(input logic [FS_W-1:0] fs);
        return (fs == FS_SLL) || (fs == FS_SRL) || (fs == FS_SRA);
    endfunction

endpackage

// File: rtl/shft_step.sv
// ---------------------------------------------------------------------------
// shft_step
// Combinational single-bit shift step used by shft_seq on every SHIFT cycle.
// Ports:
//   value   in  32  current operand
//   fs      in  5   function select (SLL / SRL / SRA)
//   shifted out 32  operand shifted by one position
//   carry   out 1   bit shifted out (0 for a non-shift code)
// ---------------------------------------------------------------------------
module shft_step
    import shft_seq_pkg::*;
(
    input  logic [DATA_W-1:0] value,
    input  logic [FS_W-1:0]   fs,
    output logic [DATA_W-1:0] shifted,
    output logic              carry
);

    // NOTE: every output gets a default before the case so no path leaves it
    // unassigned; a missing default here would infer a latch.
    always_comb begin
        shifted = value;
        carry   = 1'b0;
        case (fs)
            FS_SLL: begin
                carry   = value[DATA_W-1];
                shifted = {value[DATA_W-2:0], 1'b0};
            end
            FS_SRL: begin
                carry   = value[0];
                shifted = {1'b0, value[DATA_W-1:1]};
            end
            FS_SRA: begin
                carry   = value[0];
                shifted = {value[DATA_W-1], value[DATA_W-1:1]};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/shft_seq.sv
// ---------------------------------------------------------------------------
// shft_seq
// Multi-cycle shifter: performs a shift of T by shamnt positions one bit per
// clock, then pulses done for one cycle with the result held in Y_lo.
// Ports:
//   clk     in  1   rising-edge clock
//   reset   in  1   asynchronous active-low reset
//   start   in  1   request an operation (sampled only in IDLE)
//   FS      in  5   function select: 0C SLL, 0D SRL, 0E SRA
//   shamnt  in  5   shift amount 0-31
//   T       in  32  operand
//   busy    out 1   high whenever the FSM is not IDLE
//   done    out 1   one-cycle pulse, result valid
//   Y_lo    out 32  result, held until the next accepted start
//   C/N/Z/V out 1   carry, negative, zero, overflow (V tied 0)
//   illegal out 1   FS was not a shift code, held with Y_lo
// ---------------------------------------------------------------------------
module shft_seq
    import shft_seq_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [FS_W-1:0]    FS,
    input  logic [COUNT_W-1:0] shamnt,
    input  logic [DATA_W-1:0]  T,
    output logic               busy,
    output logic               done,
    output logic [DATA_W-1:0]  Y_lo,
    output logic               C,
    output logic               N,
    output logic               Z,
    output logic               V,
    output logic               illegal
);

    state_t             state;
    state_t             state_next;
    logic [FS_W-1:0]    fs_q;
    logic [COUNT_W-1:0] count;
    logic [DATA_W-1:0]  step_y;
    logic               step_c;
    logic               accept;

    assign accept = (state == ST_IDLE) && start;

    shft_step u_step (
        .value   (Y_lo),
        .fs      (fs_q),
        .shifted (step_y),
        .carry   (step_c)
    );

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    // Nothing to shift: go straight to DONE on the accepting edge.
                    if ((shamnt == '0) || !is_shift(FS)) begin
                        state_next = ST_DONE;
                    end else begin
                        state_next = ST_SHIFT;
                    end
                end
            end
            ST_SHIFT: begin
                // Pre-decrement count of 1 means this edge performs the last step.
                if (count == COUNT_W'(1)) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state != ST_IDLE);
        done = (state == ST_DONE);
    end

    // Datapath: operands are captured only at the accepting edge, so FS,
    // shamnt and T are free to change while the shift is in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fs_q    <= '0;
            count   <= '0;
            Y_lo    <= '0;
            C       <= 1'b0;
            illegal <= 1'b0;
        end else if (accept) begin
            fs_q  <= FS;
            count <= shamnt;
            C     <= 1'b0;
            if (is_shift(FS)) begin
                Y_lo    <= T;
                illegal <= 1'b0;
            end else begin
                Y_lo    <= '0;
                illegal <= 1'b1;
            end
        end else if (state == ST_SHIFT) begin
            Y_lo  <= step_y;
            C     <= step_c;
            count <= count - COUNT_W'(1);
        end
    end

    assign Z = (Y_lo == '0);
    assign N = Y_lo[DATA_W-1];
    assign V = 1'b0;

endmodule

// File: tb/tb_shft_seq.sv
// ---------------------------------------------------------------------------
// tb_shft_seq
// Directed self-checking bench for shft_seq. Outputs are sampled 1 time unit
// after each rising edge; inputs are driven at the same point.
// ---------------------------------------------------------------------------
module tb_shft_seq;

    localparam logic [4:0] SLL = 5'h0C;
    localparam logic [4:0] SRL = 5'h0D;
    localparam logic [4:0] SRA = 5'h0E;

    logic        clk;
    logic        reset;
    logic        start;
    logic [4:0]  FS;
    logic [4:0]  shamnt;
    logic [31:0] T;
    logic        busy;
    logic        done;
    logic [31:0] Y_lo;
    logic        C;
    logic        N;
    logic        Z;
    logic        V;
    logic        illegal;

    int total = 0;
    int bad   = 0;

    shft_seq dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .FS      (FS),
        .shamnt  (shamnt),
        .T       (T),
        .busy    (busy),
        .done    (done),
        .Y_lo    (Y_lo),
        .C       (C),
        .N       (N),
        .Z       (Z),
        .V       (V),
        .illegal (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one operation starting from an IDLE cycle (called 1 unit after an
    // edge). Checks latency, SHIFT duration, result and flags during done, then
    // the one-cycle done pulse. With poke_done, start is raised during DONE and
    // must be ignored.
    task automatic run_op(input string tag, input logic [4:0] fs, input logic [4:0] amt,
                          input logic [31:0] t, input logic [31:0] exp_y,
                          input logic exp_c, input logic exp_ill, input logic poke_done);
        int lat;
        int shift_cycles;
        int exp_lat;
        exp_lat = exp_ill ? 0 : int'(amt);
        FS = fs; shamnt = amt; T = t; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        // Scramble operands: they must not affect the in-flight operation.
        FS = 5'h1F; shamnt = 5'd17; T = 32'hDEADBEEF;
        lat = 0;
        shift_cycles = 0;
        while (!done && lat < 40) begin
            if (busy) shift_cycles++;
            @(posedge clk); #1;
            lat++;
        end
        check({tag, ".latency"}, lat, exp_lat);
        check({tag, ".shift_cycles"}, shift_cycles, exp_lat);
        check({tag, ".busy_in_done"}, {31'b0, busy}, 32'd1);
        check({tag, ".Y_lo"}, Y_lo, exp_y);
        check({tag, ".C"}, {31'b0, C}, {31'b0, exp_c});
        check({tag, ".N"}, {31'b0, N}, {31'b0, exp_y[31]});
        check({tag, ".Z"}, {31'b0, Z}, {31'b0, (exp_y == 32'h0)});
        check({tag, ".V"}, {31'b0, V}, 32'd0);
        check({tag, ".illegal"}, {31'b0, illegal}, {31'b0, exp_ill});
        if (poke_done) start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, ".done_pulse"}, {31'b0, done}, 32'd0);
        check({tag, ".idle"}, {31'b0, busy}, 32'd0);
        check({tag, ".Y_hold"}, Y_lo, exp_y);
        if (poke_done) begin
            @(posedge clk); #1;
            check({tag, ".start_in_done_ignored"}, {31'b0, busy}, 32'd0);
        end
    endtask

    initial begin
        int dones;
        reset = 1'b0; start = 1'b0; FS = '0; shamnt = '0; T = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst.busy", {31'b0, busy}, 32'd0);
        check("rst.done", {31'b0, done}, 32'd0);
        check("rst.Y_lo", Y_lo, 32'h0);
        check("rst.C", {31'b0, C}, 32'd0);
        check("rst.illegal", {31'b0, illegal}, 32'd0);
        check("rst.Z", {31'b0, Z}, 32'd1);
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;

        // Directed operations, issued back to back.
        run_op("sll1",   SLL,   5'd1,  32'h80000001, 32'h00000002, 1'b1, 1'b0, 1'b0);
        run_op("sra4",   SRA,   5'd4,  32'h80000000, 32'hF8000000, 1'b0, 1'b0, 1'b0);
        run_op("sra31",  SRA,   5'd31, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
        run_op("srl4",   SRL,   5'd4,  32'h0000000F, 32'h00000000, 1'b1, 1'b0, 1'b0);
        run_op("sll0",   SLL,   5'd0,  32'h00001234, 32'h00001234, 1'b0, 1'b0, 1'b0);
        run_op("illeg",  5'h02, 5'd5,  32'h12345678, 32'h00000000, 1'b0, 1'b1, 1'b0);
        run_op("srl8",   SRL,   5'd8,  32'hA5A5A5A5, 32'h00A5A5A5, 1'b1, 1'b0, 1'b0);
        run_op("sll12",  SLL,   5'd12, 32'h12345678, 32'h45678000, 1'b1, 1'b0, 1'b0);
        run_op("sra2",   SRA,   5'd2,  32'h80000000, 32'hE0000000, 1'b0, 1'b0, 1'b1);

        // start pulsed during SHIFT must be ignored: exactly one done.
        FS = SLL; shamnt = 5'd6; T = 32'h00000001; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        FS = SRL; shamnt = 5'd3; T = 32'hFFFFFFFF; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        dones = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done) dones++;
        end
        check("busy_start.dones", dones, 32'd1);
        check("busy_start.Y_lo", Y_lo, 32'h00000040);
        check("busy_start.C", {31'b0, C}, 32'd0);
        check("busy_start.idle", {31'b0, busy}, 32'd0);

        // Reset two edges into a shamnt=8 operation.
        FS = SLL; shamnt = 5'd8; T = 32'hC0000001; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        check("mid.Y_lo", Y_lo, 32'h00000004);
        check("mid.C", {31'b0, C}, 32'd1);
        check("mid.busy", {31'b0, busy}, 32'd1);
        reset = 1'b0;
        #1;
        check("midrst.Y_lo", Y_lo, 32'h0);
        check("midrst.C", {31'b0, C}, 32'd0);
        check("midrst.busy", {31'b0, busy}, 32'd0);
        check("midrst.done", {31'b0, done}, 32'd0);
        check("midrst.illegal", {31'b0, illegal}, 32'd0);
        dones = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done) dones++;
        end
        check("midrst.no_done", dones, 32'd0);
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;
        run_op("after_rst", SRL, 5'd3, 32'h80000008, 32'h10000001, 1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
